// File: rtl/nq_ex_pkg.sv
// Shared constants, state encoding and sign-extension helper for the NanoQuarter execute stage.
package nq_ex_pkg;

  localparam int unsigned XW = 64;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_I    = 2'b01;
  localparam logic [1:0] OP_MEM  = 2'b10;
  localparam logic [1:0] OP_CTRL = 2'b11;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_SLL = 3'b101;
  localparam logic [2:0] F_SRL = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;

  localparam logic [2:0] FI_ADDI = 3'b000;
  localparam logic [2:0] FI_ORI  = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_MEM  = 2'd2
  } state_e;

  // Sign-extends the low w bits of v to XW bits; callers cast down to the width they need.
  function automatic logic [XW-1:0] sext_w(input logic [XW-1:0] v, input int unsigned w);
    logic [XW-1:0] keep;
    logic          sign;
    keep = (XW'(1) << w) - XW'(1);
    sign = |(v & (XW'(1) << (w - 1)));
    return sign ? (v | ~keep) : (v & keep);
  endfunction

endpackage

// File: rtl/nq_ex_if.sv
// Instruction, memory, writeback and redirect signals of the execute stage.
interface nq_ex_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMM_W   = 8,
  parameter int unsigned BOFF_W  = 5,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [2:0]         in_funct;
  logic [SHAMT_W-1:0] in_shamt;
  logic [DATA_W-1:0]  in_reg1;
  logic [DATA_W-1:0]  in_reg2;
  logic [IMM_W-1:0]   in_imm;
  logic [IMM_W-1:0]   in_jtarget;
  logic [BOFF_W-1:0]  in_boff;
  logic               in_bne;
  logic               in_jmp;
  logic               in_jr;
  logic               in_memread;
  logic               in_memwrite;
  logic [2:0]         in_rd;
  logic [PC_W-1:0]    in_pc;

  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ack;
  logic [DATA_W-1:0]  mem_rdata;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_result;
  logic [2:0]         out_rd;
  logic               out_regwrite;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  modport slave (
    input  in_valid, in_op, in_funct, in_shamt, in_reg1, in_reg2, in_imm, in_jtarget,
           in_boff, in_bne, in_jmp, in_jr, in_memread, in_memwrite, in_rd, in_pc,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output out_valid, out_result, out_rd, out_regwrite,
    input  out_ready,
    output redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, in_op, in_funct, in_shamt, in_reg1, in_reg2, in_imm, in_jtarget,
           in_boff, in_bne, in_jmp, in_jr, in_memread, in_memwrite, in_rd, in_pc,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  out_valid, out_result, out_rd, out_regwrite,
    output out_ready,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/nq_iter_mul.sv
// Shift-add multiplier: start loads operands, done pulses W cycles later with the low W product bits.
module nq_iter_mul #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     acc_q, acc_d, a_q, a_d, b_q, b_d, acc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // The final partial sum is exposed combinationally so the result lands on the done edge.
  assign acc_step = acc_q + (b_q[0] ? a_q : '0);
  assign done     = busy_q && (cnt_q == CNT_W'(W - 1));
  assign product  = acc_step;

  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      acc_d  = '0;
      a_d    = a;
      b_d    = b;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_step;
      a_d    = a_q << 1;
      b_d    = b_q >> 1;
      cnt_d  = cnt_q + CNT_W'(1);
      busy_d = !done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/nq_ex_stage.sv
// Registered NanoQuarter execute stage: ALU, load/store, branch/jump redirect.
// Define NQ_EX_MUL_EN to build the iterative multiplier and MUL state.
module nq_ex_stage
  import nq_ex_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMM_W   = 8,
  parameter int unsigned BOFF_W  = 5,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic    clk,
  input  logic    rst,
  nq_ex_if.slave  bus
);
  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [2:0]        out_rd_q, out_rd_d, rd_q, rd_d;
  logic              out_regwrite_q, out_regwrite_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              in_ready, accept, ctrl_taken;
  logic [DATA_W-1:0] imm_s, r_result;
  logic [PC_W-1:0]   ctrl_target;

`ifdef NQ_EX_MUL_EN
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  nq_iter_mul #(.W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.in_reg1),
    .b       (bus.in_reg2),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Gating with rst holds in_ready low while reset is asserted.
  assign in_ready = rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    imm_s = DATA_W'(sext_w(XW'(bus.in_imm), IMM_W));
    case (bus.in_funct)
      F_ADD:   r_result = bus.in_reg1 + bus.in_reg2;
      F_SUB:   r_result = bus.in_reg1 - bus.in_reg2;
      F_AND:   r_result = bus.in_reg1 & bus.in_reg2;
      F_OR:    r_result = bus.in_reg1 | bus.in_reg2;
      F_XOR:   r_result = bus.in_reg1 ^ bus.in_reg2;
      F_SLL:   r_result = bus.in_reg1 << bus.in_shamt;
      F_SRL:   r_result = bus.in_reg1 >> bus.in_shamt;
      default: r_result = '0;
    endcase
    ctrl_taken  = 1'b0;
    ctrl_target = '0;
    if (bus.in_jr) begin
      ctrl_taken  = 1'b1;
      ctrl_target = PC_W'(bus.in_reg1);
    end else if (bus.in_jmp) begin
      ctrl_taken  = 1'b1;
      ctrl_target = bus.in_pc + PC_W'(sext_w(XW'(bus.in_jtarget), IMM_W));
    end else if (bus.in_bne) begin
      ctrl_taken  = (bus.in_reg1 != bus.in_reg2);
      ctrl_target = bus.in_pc + PC_W'(1) + PC_W'(sext_w(XW'(bus.in_boff), BOFF_W));
    end
  end

  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q && !bus.out_ready;
    out_result_d     = out_result_q;
    out_rd_d         = out_rd_q;
    out_regwrite_d   = out_regwrite_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    rd_d             = rd_q;
`ifdef NQ_EX_MUL_EN
    mul_start        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.in_op)
            OP_R: begin
              out_rd_d = bus.in_rd;
              if (bus.in_funct == F_MUL) begin
`ifdef NQ_EX_MUL_EN
                state_d   = S_MUL;
                mul_start = 1'b1;
                rd_d      = bus.in_rd;
`else
                out_valid_d    = 1'b1;
                out_result_d   = '0;
                out_regwrite_d = 1'b0;
`endif
              end else begin
                out_valid_d    = 1'b1;
                out_result_d   = r_result;
                out_regwrite_d = 1'b1;
              end
            end
            OP_I: begin
              out_valid_d = 1'b1;
              out_rd_d    = bus.in_rd;
              case (bus.in_funct)
                FI_ADDI: begin
                  out_result_d   = bus.in_reg1 + imm_s;
                  out_regwrite_d = 1'b1;
                end
                FI_ORI: begin
                  out_result_d   = bus.in_reg1 | DATA_W'(bus.in_imm);
                  out_regwrite_d = 1'b1;
                end
                default: begin
                  out_result_d   = '0;
                  out_regwrite_d = 1'b0;
                end
              endcase
            end
            OP_MEM: begin
              if (bus.in_memread || bus.in_memwrite) begin
                state_d     = S_MEM;
                mem_req_d   = 1'b1;
                mem_we_d    = !bus.in_memread;
                mem_addr_d  = ADDR_W'(bus.in_reg1 + imm_s);
                mem_wdata_d = bus.in_reg2;
                rd_d        = bus.in_rd;
              end else begin
                out_valid_d    = 1'b1;
                out_result_d   = '0;
                out_rd_d       = bus.in_rd;
                out_regwrite_d = 1'b0;
              end
            end
            default: begin
              if (ctrl_taken) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = ctrl_target;
              end
            end
          endcase
        end
      end
`ifdef NQ_EX_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          state_d        = S_IDLE;
          out_valid_d    = 1'b1;
          out_result_d   = mul_product;
          out_rd_d       = rd_q;
          out_regwrite_d = 1'b1;
        end
      end
`endif
      S_MEM: begin
        if (bus.mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            out_valid_d    = 1'b1;
            out_result_d   = bus.mem_rdata;
            out_rd_d       = rd_q;
            out_regwrite_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_rd_q         <= '0;
      out_regwrite_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      rd_q             <= '0;
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_rd_q         <= out_rd_d;
      out_regwrite_q   <= out_regwrite_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      rd_q             <= rd_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_regwrite   = out_regwrite_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
endmodule
